// File: rtl/serial_link_pkg.sv
// serial_link_pkg
//   Definitions shared by the serial link blocks:
//     rx_state_t    - receiver FSM states
//     START_BIT     - line level of the start bit
//     STOP_BIT      - line level of the stop bit
//     sample_cnt_w  - width of a counter that spans one bit period
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of the sample counter for a given bit period. This is never less
  // than one bit, so a degenerate period still yields a legal vector.
  function automatic int sample_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_bit_sync_2ff.sv
// bit_sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Parameters: RST_VAL - value both flops take during reset.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous reset, active low
//     d     - asynchronous input
//     q     - synchronized output, two clk cycles behind d
module bit_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receives frames of the form start(0), DATA_W data bits MSB first,
//   [parity], stop(1). It then presents each word through a single holding
//   register with a valid/ready handshake.
//   Build option: define SERIAL_FRAME_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit, together with the parity_err port.
//   Parameters: DATA_W (bits per word), CLKS_PER_BIT (clk cycles per bit, >= 2)
//   Ports:
//     clk, rst_n   - clock and asynchronous active-low reset
//     serial_in    - serial line, idles high
//     data_out     - received word, stable while data_valid is high
//     data_valid   - holding register contains an unconsumed word
//     data_ready   - consumer takes the word when data_valid & data_ready
//     busy         - FSM is not in IDLE
//     frame_err    - one-cycle pulse, stop bit sampled as 0 (word dropped)
//     overrun_err  - one-cycle pulse, completed word dropped because the
//                    holding register was full
//     parity_err   - (parity builds only) one-cycle pulse on parity mismatch
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun_err
`ifdef SERIAL_FRAME_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CNT_W = sample_cnt_w(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  // The sample counter stops at the end of a bit period instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_LAST) ? v : v + 1'b1;
  endfunction

  rx_state_t         state;
  logic              line;
  logic              line_q;
  logic [CNT_W-1:0]  sample_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              bit_sample;
  logic              stop_sample;
  logic              commit;
`ifdef SERIAL_FRAME_PARITY_EN
  logic              parity_bit;
`endif

  // ---- stage: line synchronization ----
  bit_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_in),
    .q     (line)
  );

  assign bit_sample  = (sample_cnt == CNT_LAST);
  assign stop_sample = (state == STOP) && bit_sample;
  assign commit      = stop_sample && (line == STOP_BIT);
  assign busy        = (state != IDLE);

  // ---- stage: frame FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_q     <= 1'b1;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      line_q <= line;
      case (state)
        IDLE: begin
          if (line_q == STOP_BIT && line == START_BIT) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          // Check the start bit at its centre. A line that is already high
          // again was a glitch, so drop back silently.
          if (sample_cnt == CNT_HALF) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            state      <= (line == START_BIT) ? DATA : IDLE;
          end else begin
            sample_cnt <= sat_inc(sample_cnt);
          end
        end
        DATA: begin
          if (bit_sample) begin
            sample_cnt <= '0;
            shift_reg  <= {shift_reg[DATA_W-2:0], line};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            sample_cnt <= sat_inc(sample_cnt);
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        PARITY: begin
          if (bit_sample) begin
            sample_cnt <= '0;
            parity_bit <= line;
            state      <= STOP;
          end else begin
            sample_cnt <= sat_inc(sample_cnt);
          end
        end
`endif
        STOP: begin
          if (bit_sample) begin
            sample_cnt <= '0;
            state      <= IDLE;
          end else begin
            sample_cnt <= sat_inc(sample_cnt);
          end
        end
        default: begin
          state      <= IDLE;
          sample_cnt <= '0;
        end
      endcase
    end
  end

  // ---- stage: holding register and status pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= stop_sample && (line != STOP_BIT);
      overrun_err <= commit && data_valid && !data_ready;
`ifdef SERIAL_FRAME_PARITY_EN
      parity_err  <= stop_sample && (^{shift_reg, parity_bit});
`endif
      // A commit that coincides with a handshake replaces the consumed word
      // and keeps data_valid high.
      if (commit && (!data_valid || data_ready)) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Directed and random frames are driven into serial_frame_receiver. The
//   delivered words and the error pulses are compared against a
//   transaction-level model of the holding register.
module tb_serial_frame_receiver;

  localparam int DATA_W = 8;
  localparam int CLKS   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              serial_in = 1'b1;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              frame_err;
  logic              overrun_err;
`ifdef SERIAL_FRAME_PARITY_EN
  logic              parity_err;
  logic              par_flip_g = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_frame_receiver #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
`ifdef SERIAL_FRAME_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  // Observed traffic, sampled on the falling edge.
  logic [DATA_W-1:0] got_q[$];
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  int vld_cycles = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) vld_cycles <= vld_cycles + 1;
      if (data_valid && data_ready) got_q.push_back(data_out);
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun_err) ovr_cnt <= ovr_cnt + 1;
`ifdef SERIAL_FRAME_PARITY_EN
      if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
    end
  end

  // Reference model: one entry per frame, holding register as valid + word.
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic [DATA_W-1:0] exp_q[$];
  int exp_ferr = 0;
  int exp_ovr = 0;
  int exp_perr = 0;

  task automatic model_frame(input logic [DATA_W-1:0] d, input logic stop_ok);
    if (!stop_ok) begin
      exp_ferr++;
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = d;
    end else if (data_ready) begin
      exp_q.push_back(m_data);
      m_data = d;
    end else begin
      exp_ovr++;
    end
`ifdef SERIAL_FRAME_PARITY_EN
    if (par_flip_g) exp_perr++;
`endif
    if (m_valid && data_ready) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic model_set_ready(input logic r);
    data_ready = r;
    if (r && m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CLKS) tick();
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) drive_bit(d[i]);
`ifdef SERIAL_FRAME_PARITY_EN
    drive_bit((^d) ^ par_flip_g);
`endif
    drive_bit(stop_bit);
    serial_in = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] g;
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 'x;
      if (i < got_q.size()) g = 32'(got_q[i]);
      chk({tag, "_word"}, g, 32'(exp_q[i]));
    end
    chk({tag, "_frame_err_cnt"}, ferr_cnt, exp_ferr);
    chk({tag, "_overrun_cnt"}, ovr_cnt, exp_ovr);
    chk({tag, "_parity_err_cnt"}, perr_cnt, exp_perr);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              rstop;

    // Reset state
    repeat (3) tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun_err", overrun_err, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single frame 0xA5 with the consumer ready
    model_set_ready(1'b1);
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    repeat (4) tick();
    check_all("a5");
    chk("a5_valid_cycles", vld_cycles, 1);
    chk("a5_valid_low", data_valid, 0);

    // One-cycle glitch on the line
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    tick();
    tick();
    chk("glitch_busy_start", busy, 1);
    repeat (4) tick();
    check_all("glitch");
    chk("glitch_valid_cycles", vld_cycles, 1);

    // Bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    repeat (3) tick();
    chk("ferr_valid", data_valid, 0);
    check_all("ferr");
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    repeat (4) tick();
    check_all("after_ferr");

    // Back-to-back frames with the consumer stalled
    model_set_ready(1'b0);
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1);
    repeat (3) tick();
    chk("ovr_data_out", data_out, 8'h11);
    chk("ovr_valid", data_valid, 1);
    check_all("ovr");
    model_set_ready(1'b1);
    tick();
    chk("ovr_release_valid", data_valid, 0);
    check_all("ovr_release");

    // Reset in the middle of the data bits of 0xFF
    drive_bit(1'b0);
    serial_in = 1'b1;
    repeat (3 * CLKS) tick();
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_err", frame_err, 0);
    m_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    repeat (4) tick();
    check_all("after_midrst");

    // Random frames: random data, stop bit and consumer readiness
    for (int n = 0; n < 12; n++) begin
      rd    = DATA_W'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      model_set_ready(1'($urandom_range(0, 1)));
`ifdef SERIAL_FRAME_PARITY_EN
      par_flip_g = 1'($urandom_range(0, 1));
`endif
      send_frame(rd, rstop);
      model_frame(rd, rstop);
      repeat (3) tick();
    end
    model_set_ready(1'b1);
    repeat (2) tick();
    check_all("random");

`ifdef SERIAL_FRAME_PARITY_EN
    // Parity: wrong parity bit still commits the word, then correct parity
    par_flip_g = 1'b1;
    send_frame(8'h07, 1'b1);
    model_frame(8'h07, 1'b1);
    repeat (4) tick();
    chk("par_bad_word", data_out, 8'h07);
    check_all("par_bad");
    par_flip_g = 1'b0;
    send_frame(8'h07, 1'b1);
    model_frame(8'h07, 1'b1);
    repeat (4) tick();
    check_all("par_good");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
